// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF response generator: measures N_BITS RO pairs in turn and
// emits one response bit per pair. Define PUF_MAJORITY_EN for a 3-trial majority vote per pair.
module puf_resp_gen #(
  parameter  int N_BITS = 16,
  parameter  int WINDOW = 100000,
  parameter  int SETTLE = 16,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              ro_en,
  output logic [IDX_W-1:0]  pair_idx,
  output logic              busy,
  output logic [N_BITS-1:0] resp,
  output logic              resp_valid,
  output logic [CNT_W-1:0]  diff
);

  localparam int TMR_N = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W = $clog2(TMR_N);
  localparam logic [TMR_W-1:0] SET_LD   = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WIN_LD   = TMR_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + CNT_W'(1));
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

`ifdef PUF_MAJORITY_EN
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction
`endif

  state_t              state_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [CNT_W-1:0]    cnt_a_q, cnt_b_q;
  logic [N_BITS-1:0]   bits_q;
  logic                ro_en_q, busy_q, resp_valid_q;
  logic [IDX_W-1:0]    pair_idx_q;
  logic [N_BITS-1:0]   resp_q;
  logic [CNT_W-1:0]    diff_q;
`ifdef PUF_MAJORITY_EN
  logic [1:0]          trial_q;
  logic [1:0]          votes_q;
`endif

  logic [1:0]          sync_a_q, sync_b_q;
  logic                prev_a_q, prev_b_q;
  logic                edge_a_q, edge_b_q;

  logic                a_gt_b_d;
  logic                bit_d;
  logic                pair_done_d;
  logic                last_pair_d;
  logic [CNT_W-1:0]    diff_d;

  // Input stage: 2-flop synchronizers followed by a registered rising-edge pulse
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
      edge_a_q <= 1'b0;
      edge_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[0], ro_a};
      sync_b_q <= {sync_b_q[0], ro_b};
      prev_a_q <= sync_a_q[1];
      prev_b_q <= sync_b_q[1];
      edge_a_q <= sync_a_q[1] & ~prev_a_q;
      edge_b_q <= sync_b_q[1] & ~prev_b_q;
    end
  end

  always_comb begin
    a_gt_b_d    = (cnt_a_q > cnt_b_q);
    diff_d      = abs_diff(cnt_a_q, cnt_b_q);
    last_pair_d = (pair_idx_q == LAST_IDX);
`ifdef PUF_MAJORITY_EN
    pair_done_d = (trial_q == 2'd2);
    bit_d       = maj3(votes_q[1], votes_q[0], a_gt_b_d);
`else
    pair_done_d = 1'b1;
    bit_d       = a_gt_b_d;
`endif
  end

  // Control stage: sequencing FSM with registered outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      bits_q       <= '0;
      ro_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      pair_idx_q   <= '0;
      resp_q       <= '0;
      diff_q       <= '0;
`ifdef PUF_MAJORITY_EN
      trial_q      <= '0;
      votes_q      <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_SETTLE;
            busy_q     <= 1'b1;
            ro_en_q    <= 1'b1;
            pair_idx_q <= '0;
            bits_q     <= '0;
            tmr_q      <= SET_LD;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
`ifdef PUF_MAJORITY_EN
            trial_q    <= '0;
            votes_q    <= '0;
`endif
          end
        end
        S_SETTLE: begin
          // Edges seen while the oscillators warm up are discarded
          cnt_a_q <= '0;
          cnt_b_q <= '0;
          if (tmr_q == '0) begin
            state_q <= S_MEASURE;
            tmr_q   <= WIN_LD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_MEASURE: begin
          if (edge_a_q) cnt_a_q <= sat_inc(cnt_a_q);
          if (edge_b_q) cnt_b_q <= sat_inc(cnt_b_q);
          if (tmr_q == '0) begin
            state_q <= S_DECIDE;
            ro_en_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_DECIDE: begin
          if (pair_done_d) begin
            bits_q[pair_idx_q] <= bit_d;
            diff_q             <= diff_d;
            if (last_pair_d) begin
              state_q <= S_DONE;
            end else begin
              pair_idx_q <= pair_idx_q + 1'b1;
              state_q    <= S_SETTLE;
              ro_en_q    <= 1'b1;
              tmr_q      <= SET_LD;
            end
          end else begin
            state_q <= S_SETTLE;
            ro_en_q <= 1'b1;
            tmr_q   <= SET_LD;
          end
`ifdef PUF_MAJORITY_EN
          votes_q <= {votes_q[0], a_gt_b_d};
          trial_q <= pair_done_d ? 2'd0 : (trial_q + 2'd1);
`endif
        end
        S_DONE: begin
          resp_q       <= bits_q;
          resp_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          pair_idx_q   <= '0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ro_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign ro_en      = ro_en_q;
  assign pair_idx   = pair_idx_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign diff       = diff_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Bench for puf_resp_gen: table-driven directed runs plus randomized RO waveforms,
// checked against a window-counting model over the recorded input history.
`timescale 1ns/1ps
module tb_puf_resp_gen;
  localparam int N  = 2;
  localparam int W  = 100;
  localparam int S  = 4;
  localparam int CW = 4;
  localparam int IW = 1;
`ifdef PUF_MAJORITY_EN
  localparam int T = 3;
`else
  localparam int T = 1;
`endif
  localparam int P    = S + W + 1;
  localparam int RUN  = N * T * P;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          ro_a = 1'b0;
  logic          ro_b = 1'b0;
  logic          ro_en, busy, resp_valid;
  logic [IW-1:0] pair_idx;
  logic [N-1:0]  resp;
  logic [CW-1:0] diff;

  puf_resp_gen #(.N_BITS(N), .WINDOW(W), .SETTLE(S), .CNT_W(CW)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .pair_idx(pair_idx), .busy(busy), .resp(resp),
    .resp_valid(resp_valid), .diff(diff)
  );

  always #5 CLK = ~CLK;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   base = 0;
  int   pa_sel = 0;
  int   pb_sel = 0;
  int   rem_a = 0;
  int   rem_b = 0;
  logic lvl_a = 1'b0;
  logic lvl_b = 1'b0;
  logic hist_a [0:65535];
  logic hist_b [0:65535];
  logic [N-1:0] prev_resp = '0;

  typedef struct {
    int           pa;
    int           pb;
    logic [N-1:0] resp;
    int           diff;
  } vec_t;
  vec_t tab [6];

  // p>0: square wave of period p locked to the run start; 0: held low;
  // -1: period alternates 8/20 every P cycles; -2 handled as random halves.
  function automatic logic per_bit(input int p, input int ph);
    int pp;
    if (p == -1) pp = (((ph / P) % 2) == 0) ? 8 : 20;
    else         pp = p;
    if (pp <= 0 || ph < 0) return 1'b0;
    return ((ph % pp) < (pp / 2));
  endfunction

  always @(posedge CLK) begin
    hist_a[cyc] = ro_a;
    hist_b[cyc] = ro_b;
    cyc = cyc + 1;
    #1;
    if (pa_sel == -2) begin
      if (rem_a == 0) begin lvl_a = ~lvl_a; rem_a = $urandom_range(7, 2); end
      rem_a = rem_a - 1;
      ro_a = lvl_a;
    end else begin
      ro_a = per_bit(pa_sel, cyc - base);
    end
    if (pb_sel == -2) begin
      if (rem_b == 0) begin lvl_b = ~lvl_b; rem_b = $urandom_range(7, 2); end
      rem_b = rem_b - 1;
      ro_b = lvl_b;
    end else begin
      ro_b = per_bit(pb_sel, cyc - base);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Count sampled rising edges of each input over every measurement window.
  task automatic model(input int k, output logic [N-1:0] r, output int dif);
    int ca, cb, votes, lo;
    r = '0;
    dif = 0;
    for (int p = 0; p < N; p++) begin
      votes = 0;
      for (int t = 0; t < T; t++) begin
        lo = k + (p * T + t) * P + S - 2;
        ca = 0;
        cb = 0;
        for (int m = lo; m < lo + W; m++) begin
          if (hist_a[m] && !hist_a[m-1]) ca++;
          if (hist_b[m] && !hist_b[m-1]) cb++;
        end
        if (ca > CMAX) ca = CMAX;
        if (cb > CMAX) cb = CMAX;
        if (ca > cb) votes++;
        dif = (ca > cb) ? (ca - cb) : (cb - ca);
      end
      r[p] = (2 * votes > T);
    end
  endtask

  task automatic run(input int pa, input int pb, input int mid_starts, input int abort_d,
                     input logic chk_tab, input logic [N-1:0] t_resp, input int t_diff);
    int            k, mdiff;
    logic [N-1:0]  mresp, e_resp;
    logic          e_busy, e_en, e_rv;
    logic [IW-1:0] e_idx;
    mresp = prev_resp;
    mdiff = 0;
    @(negedge CLK);
    pa_sel = pa;
    pb_sel = pb;
    base   = cyc;
    k      = cyc;
    start  = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int d = 0; d <= RUN + 3; d++) begin
      if (d == abort_d) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", {ro_en, busy, pair_idx, resp, resp_valid, diff}, 64'd0);
        repeat (3) @(negedge CLK);
        check("abort_held_zero", {ro_en, busy, pair_idx, resp, resp_valid, diff}, 64'd0);
        rst_n = 1'b1;
        prev_resp = '0;
        start = 1'b0;
        return;
      end
      if (d == RUN + 1) model(k, mresp, mdiff);
      if (d < RUN) begin
        e_busy = 1'b1; e_en = ((d % P) < (S + W)); e_idx = IW'((d / P) / T);
        e_rv = 1'b0; e_resp = prev_resp;
      end else if (d == RUN) begin
        e_busy = 1'b1; e_en = 1'b0; e_idx = IW'(N - 1); e_rv = 1'b0; e_resp = prev_resp;
      end else begin
        e_busy = 1'b0; e_en = 1'b0; e_idx = '0; e_rv = (d == RUN + 1); e_resp = mresp;
      end
      check($sformatf("timeline d=%0d {busy,en,idx,rv,resp}", d),
            {busy, ro_en, pair_idx, resp_valid, resp}, {e_busy, e_en, e_idx, e_rv, e_resp});
      if (d >= RUN + 1) check($sformatf("diff d=%0d", d), diff, mdiff);
      if (d == RUN + 1 && chk_tab) begin
        check($sformatf("table_resp pa=%0d pb=%0d", pa, pb), resp, t_resp);
        if (t_diff >= 0) check($sformatf("table_diff pa=%0d pb=%0d", pa, pb), diff, t_diff);
      end
      start = (mid_starts != 0 && d <= RUN && $urandom_range(3, 0) == 0);
      @(negedge CLK);
    end
    start = 1'b0;
    prev_resp = mresp;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    tab[0] = '{10, 14, 2'b11, 3};
    tab[1] = '{14, 10, 2'b00, 3};
    tab[2] = '{10, 10, 2'b00, 0};
    tab[3] = '{4,  0,  2'b11, 15};
    tab[4] = '{0,  4,  2'b00, 15};
    tab[5] = '{-1, 14, 2'b01, -1};

    #3 rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {ro_en, busy, pair_idx, resp, resp_valid, diff}, 64'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("idle_no_start", {ro_en, busy, pair_idx, resp, resp_valid, diff}, 64'd0);
    end

    for (int i = 0; i < 6; i++)
      run(tab[i].pa, tab[i].pb, 0, -1, 1'b1, tab[i].resp, tab[i].diff);

    run(10, 14, 1, -1, 1'b1, 2'b11, 3);
    run(10, 14, 0, T * P + S + 20, 1'b0, '0, 0);
    run(14, 10, 0, -1, 1'b1, 2'b00, 3);

    for (int i = 0; i < 6; i++)
      run(-2, -2, int'($urandom_range(1, 0)), -1, 1'b0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
